// File: rtl/u409_tod_pkg.sv
// u409_tod_pkg
//   Shared constants for the U409 time-of-day counter.
//   TOD_W            counter / alarm width
//   REG_LSB/MID/HI   REG_SEL offsets of the three byte registers
//   REG_NONE         unused offset (reads 8'h00, writes ignored)
//   tod_byte()       picks the byte addressed by a REG_SEL value
package u409_tod_pkg;

    localparam int TOD_W = 24;

    localparam logic [1:0] REG_LSB  = 2'd0;
    localparam logic [1:0] REG_MID  = 2'd1;
    localparam logic [1:0] REG_HI   = 2'd2;
    localparam logic [1:0] REG_NONE = 2'd3;

    function automatic logic [7:0] tod_byte(input logic [TOD_W-1:0] value,
                                            input logic [1:0]       sel);
        logic [7:0] b;
        b = 8'h00;
        case (sel)
            REG_LSB: b = value[7:0];
            REG_MID: b = value[15:8];
            REG_HI:  b = value[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/u409_tick_sync.sv
// u409_tick_sync
//   Brings the asynchronous 50/60Hz TICK into the CLK6 domain and turns each
//   low-to-high transition into a single-cycle pulse. A TICK held high for
//   any number of cycles yields exactly one pulse.
//   Latency from TICK rising to tick_p high is SYNC_STAGES+1 CLK6 cycles.
// Parameters
//   SYNC_STAGES  synchroniser depth, must be >= 2
// Ports
//   CLK6    in  system clock
//   RESETn  in  asynchronous active-low reset
//   TICK    in  asynchronous tick input
//   tick_p  out registered one-cycle pulse per TICK rising edge
module u409_tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK6,
    input  logic RESETn,
    input  logic TICK,
    output logic tick_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK6 or negedge RESETn) begin
        if (!RESETn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], TICK};
            prev_q <= sync_q[SYNC_STAGES-1];
            // Edge detect on the last synchroniser stage only.
            tick_p <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/u409_tod_counter.sv
// u409_tod_counter
//   CIA/8520-style 24-bit time-of-day event counter clocked by CLK6.
//   Counts rising edges of TICK, exposes the count as three byte registers
//   with read-latch / write-stop semantics, and pulses ALARM_IRQ for one
//   cycle when the count becomes equal to the alarm register.
// Build option
//   TOD_ALARM_READBACK_EN  when defined, RD with ALARM_SEL=1 returns alarm
//                          bytes; otherwise the alarm is write-only and RD
//                          ignores ALARM_SEL.
// Parameters
//   SYNC_STAGES  TICK synchroniser depth (>= 2)
//   ALARM_RESET  alarm register value after reset
// Ports
//   CLK6       in   system clock
//   RESETn     in   asynchronous active-low reset
//   TICK       in   50/60Hz tick, asynchronous
//   REG_SEL    in   0=LSB 1=MID 2=HI 3=unused
//   WR         in   write strobe, DIN valid in the same cycle
//   RD         in   read strobe, DOUT valid the following cycle
//   DIN        in   write data
//   ALARM_SEL  in   1: writes target the alarm, 0: the counter
//   DOUT       out  registered read data, holds its value between reads
//   ALARM_IRQ  out  one-cycle alarm pulse
//
// Bus strobes: WR and RD are single-cycle qualifiers sampled on the CLK6
// edge; there is no back-pressure. A read issued together with a write
// returns the pre-write state because both use the current register values.
module u409_tod_counter
    import u409_tod_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [TOD_W-1:0] ALARM_RESET = 24'h000000
) (
    input  logic       CLK6,
    input  logic       RESETn,
    input  logic       TICK,
    input  logic [1:0] REG_SEL,
    input  logic       WR,
    input  logic       RD,
    input  logic [7:0] DIN,
    input  logic       ALARM_SEL,
    output logic [7:0] DOUT,
    output logic       ALARM_IRQ
);

    logic             tick_p;
    logic [TOD_W-1:0] count, count_nxt;
    logic [TOD_W-1:0] alarm, alarm_nxt;
    logic [TOD_W-1:0] latch;
    logic [TOD_W-1:0] rd_src;
    logic             running, running_nxt;
    logic             latched;
    logic             match, match_q;
    logic             wr_cnt, wr_alarm;
    logic             rd_cnt;
    logic [7:0]       rd_data;

    u409_tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .CLK6  (CLK6),
        .RESETn(RESETn),
        .TICK  (TICK),
        .tick_p(tick_p)
    );

    assign wr_cnt   = WR && !ALARM_SEL && (REG_SEL != REG_NONE);
    assign wr_alarm = WR &&  ALARM_SEL && (REG_SEL != REG_NONE);

`ifdef TOD_ALARM_READBACK_EN
    // Alarm reads bypass the counter latch entirely.
    assign rd_cnt = RD && !ALARM_SEL;
`else
    assign rd_cnt = RD;
`endif

    // Counter next state. A counter write of any byte wins over a
    // coincident tick; that tick's increment is lost. Writing HI stops the
    // counter so a multi-byte update cannot ripple, writing LSB restarts it.
    always_comb begin
        count_nxt   = count;
        running_nxt = running;
        if (wr_cnt) begin
            case (REG_SEL)
                REG_LSB: begin
                    count_nxt[7:0] = DIN;
                    running_nxt    = 1'b1;
                end
                REG_MID: count_nxt[15:8] = DIN;
                REG_HI: begin
                    count_nxt[23:16] = DIN;
                    running_nxt      = 1'b0;
                end
                default: ;
            endcase
        end else if (tick_p && running) begin
            count_nxt = count + 24'd1;
        end
    end

    always_comb begin
        alarm_nxt = alarm;
        if (wr_alarm) begin
            case (REG_SEL)
                REG_LSB: alarm_nxt[7:0]   = DIN;
                REG_MID: alarm_nxt[15:8]  = DIN;
                REG_HI:  alarm_nxt[23:16] = DIN;
                default: ;
            endcase
        end
    end

    // HI always reads live (it is the byte that arms the latch); MID/LSB
    // read the snapshot while one is held.
    always_comb begin
        rd_src  = (latched && (REG_SEL != REG_HI)) ? latch : count;
        rd_data = tod_byte(rd_src, REG_SEL);
`ifdef TOD_ALARM_READBACK_EN
        if (ALARM_SEL) begin
            rd_data = tod_byte(alarm, REG_SEL);
        end
`endif
    end

    assign match = (count == alarm);

    always_ff @(posedge CLK6 or negedge RESETn) begin
        if (!RESETn) begin
            count     <= '0;
            alarm     <= ALARM_RESET;
            running   <= 1'b1;
            latch     <= '0;
            latched   <= 1'b0;
            DOUT      <= 8'h00;
            // Starting high suppresses a pulse when ALARM_RESET equals zero.
            match_q   <= 1'b1;
            ALARM_IRQ <= 1'b0;
        end else begin
            count   <= count_nxt;
            alarm   <= alarm_nxt;
            running <= running_nxt;

            if (RD) begin
                DOUT <= rd_data;
            end

            if (rd_cnt && (REG_SEL == REG_HI)) begin
                latch   <= count;
                latched <= 1'b1;
            end else if (rd_cnt && (REG_SEL == REG_LSB)) begin
                latched <= 1'b0;
            end

            match_q   <= match;
            ALARM_IRQ <= match & ~match_q;
        end
    end

endmodule

// File: tb/tb_u409_tod_counter.sv
module tb_u409_tod_counter;

    logic       CLK6;
    logic       RESETn;
    logic       TICK;
    logic [1:0] REG_SEL;
    logic       WR;
    logic       RD;
    logic [7:0] DIN;
    logic       ALARM_SEL;
    logic [7:0] DOUT;
    logic       ALARM_IRQ;

    int checks;
    int errors;
    int irq_first;
    int irq_cycles;

    localparam int LOW_CYCLES = 10;

    u409_tod_counter dut (
        .CLK6     (CLK6),
        .RESETn   (RESETn),
        .TICK     (TICK),
        .REG_SEL  (REG_SEL),
        .WR       (WR),
        .RD       (RD),
        .DIN      (DIN),
        .ALARM_SEL(ALARM_SEL),
        .DOUT     (DOUT),
        .ALARM_IRQ(ALARM_IRQ)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK6 = 1'b0;
        forever #5 CLK6 = ~CLK6;
    end

    task automatic apply_reset();
        RESETn = 1'b0;
        repeat (3) @(negedge CLK6);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK6);
    endtask

    // ---------------- driver tasks (called at a negedge, end at a negedge) ----
    task automatic wr_reg(input logic [1:0] sel, input logic [7:0] data, input logic asel);
        REG_SEL   = sel;
        DIN       = data;
        ALARM_SEL = asel;
        WR        = 1'b1;
        @(negedge CLK6);
        WR        = 1'b0;
        ALARM_SEL = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] sel, input logic asel, output logic [7:0] data);
        REG_SEL   = sel;
        ALARM_SEL = asel;
        RD        = 1'b1;
        @(negedge CLK6);
        RD        = 1'b0;
        ALARM_SEL = 1'b0;
        data      = DOUT;
    endtask

    task automatic read_count(output logic [23:0] value);
        logic [7:0] b;
        rd_reg(2'd2, 1'b0, b); value[23:16] = b;
        rd_reg(2'd1, 1'b0, b); value[15:8]  = b;
        rd_reg(2'd0, 1'b0, b); value[7:0]   = b;
    endtask

    // One TICK pulse; records the negedge index (from the rise) at which
    // ALARM_IRQ was first seen high, and how many cycles it was high.
    task automatic do_tick(input int hold);
        irq_first  = 0;
        irq_cycles = 0;
        TICK = 1'b1;
        for (int i = 1; i <= hold + LOW_CYCLES; i++) begin
            if (i == hold + 1) TICK = 1'b0;
            @(negedge CLK6);
            if (ALARM_IRQ === 1'b1) begin
                irq_cycles++;
                if (irq_first == 0) irq_first = i;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESETn = 1'b0;
        #1;
        checks++;
        if (DOUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h expected 00", DOUT);
        end
        checks++;
        if (ALARM_IRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", ALARM_IRQ);
        end
        @(negedge CLK6);
        RESETn = 1'b1;
        repeat (2) @(negedge CLK6);
    endtask

    task automatic test_count_long_ticks();
        logic [23:0] v;
        int total_irq;
        total_irq = 0;
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            do_tick(1000);
            total_irq += irq_cycles;
        end
        read_count(v);
        checks++;
        if (v !== 24'h000005) begin
            errors++;
            $display("FAIL long_ticks_count: got %h expected 000005", v);
        end
        checks++;
        if (total_irq !== 0) begin
            errors++;
            $display("FAIL long_ticks_irq: got %0d high cycles expected 0", total_irq);
        end
    endtask

    task automatic test_write_stop();
        logic [23:0] v;
        apply_reset();
        wr_reg(2'd2, 8'h12, 1'b0);
        wr_reg(2'd1, 8'h34, 1'b0);
        for (int t = 0; t < 3; t++) do_tick(20);
        wr_reg(2'd0, 8'h56, 1'b0);
        for (int t = 0; t < 2; t++) do_tick(20);
        read_count(v);
        checks++;
        if (v !== 24'h123458) begin
            errors++;
            $display("FAIL write_stop_count: got %h expected 123458", v);
        end
    endtask

    task automatic test_read_latch();
        logic [7:0] b;
        apply_reset();
        wr_reg(2'd2, 8'h00, 1'b0);
        wr_reg(2'd1, 8'h00, 1'b0);
        wr_reg(2'd0, 8'hFF, 1'b0);
        rd_reg(2'd2, 1'b0, b);
        checks++;
        if (b !== 8'h00) begin errors++; $display("FAIL latch_hi: got %h expected 00", b); end
        do_tick(20);
        do_tick(20);
        rd_reg(2'd1, 1'b0, b);
        checks++;
        if (b !== 8'h00) begin errors++; $display("FAIL latch_mid: got %h expected 00", b); end
        rd_reg(2'd0, 1'b0, b);
        checks++;
        if (b !== 8'hFF) begin errors++; $display("FAIL latch_lsb: got %h expected ff", b); end
        rd_reg(2'd0, 1'b0, b);
        checks++;
        if (b !== 8'h01) begin errors++; $display("FAIL unlatched_lsb: got %h expected 01", b); end
    endtask

    task automatic test_alarm();
        apply_reset();
        wr_reg(2'd0, 8'h03, 1'b1);
        wr_reg(2'd1, 8'h00, 1'b1);
        wr_reg(2'd2, 8'h00, 1'b1);
        for (int t = 1; t <= 4; t++) begin
            do_tick(20);
            if (t == 3) begin
                // Rise at negedge 0 -> tick_p sampled at edge 4 -> count=3,
                // IRQ registered at edge 5, seen at negedge 5.
                checks++;
                if (irq_first !== 5) begin
                    errors++;
                    $display("FAIL alarm_timing: got negedge %0d expected 5", irq_first);
                end
                checks++;
                if (irq_cycles !== 1) begin
                    errors++;
                    $display("FAIL alarm_width: got %0d cycles expected 1", irq_cycles);
                end
            end else begin
                checks++;
                if (irq_cycles !== 0) begin
                    errors++;
                    $display("FAIL alarm_spurious_tick%0d: got %0d cycles expected 0", t, irq_cycles);
                end
            end
        end
    endtask

    task automatic test_wrap_and_collision();
        logic [23:0] v;
        apply_reset();
        wr_reg(2'd2, 8'hFF, 1'b0);
        wr_reg(2'd1, 8'hFF, 1'b0);
        wr_reg(2'd0, 8'hFF, 1'b0);
        do_tick(20);
        // Count wraps onto the reset alarm value of zero: one pulse.
        checks++;
        if (irq_cycles !== 1) begin
            errors++;
            $display("FAIL wrap_irq: got %0d cycles expected 1", irq_cycles);
        end
        read_count(v);
        checks++;
        if (v !== 24'h000000) begin
            errors++;
            $display("FAIL wrap_count: got %h expected 000000", v);
        end
        // Write LSB in the exact cycle tick_p is consumed (edge 4 after rise).
        TICK = 1'b1;
        repeat (3) @(negedge CLK6);
        wr_reg(2'd0, 8'h77, 1'b0);
        repeat (20) @(negedge CLK6);
        TICK = 1'b0;
        repeat (LOW_CYCLES) @(negedge CLK6);
        read_count(v);
        checks++;
        if (v !== 24'h000077) begin
            errors++;
            $display("FAIL collision_count: got %h expected 000077", v);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] b;
        logic [23:0] v;
        apply_reset();
        wr_reg(2'd2, 8'h05, 1'b0);
        wr_reg(2'd1, 8'hAB, 1'b0);
        wr_reg(2'd0, 8'h12, 1'b0);
        rd_reg(2'd2, 1'b0, b);
        TICK = 1'b1;
        @(negedge CLK6);
        RESETn = 1'b0;
        #1;
        checks++;
        if (DOUT !== 8'h00) begin
            errors++;
            $display("FAIL midreset_dout: got %h expected 00", DOUT);
        end
        checks++;
        if (ALARM_IRQ !== 1'b0) begin
            errors++;
            $display("FAIL midreset_irq: got %b expected 0", ALARM_IRQ);
        end
        TICK = 1'b0;
        repeat (2) @(negedge CLK6);
        RESETn = 1'b1;
        repeat (10) @(negedge CLK6);
        // MID first: a surviving latch would return AB here.
        rd_reg(2'd1, 1'b0, b);
        checks++;
        if (b !== 8'h00) begin
            errors++;
            $display("FAIL midreset_latch_cleared: got %h expected 00", b);
        end
        read_count(v);
        checks++;
        if (v !== 24'h000000) begin
            errors++;
            $display("FAIL midreset_count: got %h expected 000000", v);
        end
    endtask

    task automatic test_alarm_read();
        logic [7:0] b;
        apply_reset();
        wr_reg(2'd2, 8'h3C, 1'b1);
        wr_reg(2'd1, 8'h2B, 1'b1);
        wr_reg(2'd0, 8'h1A, 1'b1);
        wr_reg(2'd2, 8'h00, 1'b0);
        wr_reg(2'd1, 8'h01, 1'b0);
        wr_reg(2'd0, 8'h02, 1'b0);
`ifdef TOD_ALARM_READBACK_EN
        rd_reg(2'd2, 1'b1, b);
        checks++;
        if (b !== 8'h3C) begin errors++; $display("FAIL alarm_rb_hi: got %h expected 3c", b); end
        rd_reg(2'd1, 1'b1, b);
        checks++;
        if (b !== 8'h2B) begin errors++; $display("FAIL alarm_rb_mid: got %h expected 2b", b); end
        do_tick(20);
        rd_reg(2'd0, 1'b0, b);
        checks++;
        if (b !== 8'h03) begin errors++; $display("FAIL alarm_rb_nolatch: got %h expected 03", b); end
`else
        rd_reg(2'd2, 1'b1, b);
        checks++;
        if (b !== 8'h00) begin errors++; $display("FAIL alarm_wo_hi: got %h expected 00", b); end
        do_tick(20);
        rd_reg(2'd0, 1'b1, b);
        checks++;
        if (b !== 8'h02) begin errors++; $display("FAIL alarm_wo_latched_lsb: got %h expected 02", b); end
`endif
    endtask

    task automatic test_rd_wr_same_cycle();
        logic [7:0] b;
        apply_reset();
        wr_reg(2'd0, 8'h10, 1'b0);
        REG_SEL = 2'd0;
        DIN     = 8'h99;
        WR      = 1'b1;
        RD      = 1'b1;
        @(negedge CLK6);
        WR = 1'b0;
        RD = 1'b0;
        checks++;
        if (DOUT !== 8'h10) begin
            errors++;
            $display("FAIL rdwr_prewrite: got %h expected 10", DOUT);
        end
        rd_reg(2'd0, 1'b0, b);
        checks++;
        if (b !== 8'h99) begin errors++; $display("FAIL rdwr_postwrite: got %h expected 99", b); end
        wr_reg(2'd3, 8'hEE, 1'b0);
        rd_reg(2'd3, 1'b0, b);
        checks++;
        if (b !== 8'h00) begin errors++; $display("FAIL unused_reg: got %h expected 00", b); end
        rd_reg(2'd0, 1'b0, b);
        checks++;
        if (b !== 8'h99) begin errors++; $display("FAIL unused_write_ignored: got %h expected 99", b); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        RESETn    = 1'b0;
        TICK      = 1'b0;
        REG_SEL   = 2'd0;
        WR        = 1'b0;
        RD        = 1'b0;
        DIN       = 8'h00;
        ALARM_SEL = 1'b0;
        repeat (2) @(negedge CLK6);
        test_reset();
        test_count_long_ticks();
        test_write_stop();
        test_read_latch();
        test_alarm();
        test_wrap_and_collision();
        test_reset_mid_op();
        test_alarm_read();
        test_rd_wr_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
